// File: rtl/frame_stim_pkg.sv
// Shared types and constants for the framed stimulus generator.
// Holds payload mode encodings, FSM states, header tag and LFSR taps.
package frame_stim_pkg;

    typedef enum logic [1:0] {
        MODE_CNT  = 2'd0,
        MODE_TS   = 2'd1,
        MODE_LFSR = 2'd2,
        MODE_ONES = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAY,
        ST_TRL
    } state_e;

    localparam logic [1:0]  HDR_TAG   = 2'b11;

    // x^16+x^14+x^13+x^11+1 as a right-shifting Fibonacci register:
    // feedback is taken from bits 0,2,3,5 and enters at bit 15.
    localparam logic [15:0] LFSR_TAPS = 16'h002D;

    function automatic logic [15:0] lfsr_step(input logic [15:0] s);
        return {^(s & LFSR_TAPS), s[15:1]};
    endfunction

endpackage

// File: rtl/stim_lfsr16.sv
// 16-bit payload LFSR, advanced one step per enabled cycle.
// Ports: iclk, ireset (sync, loads SEED), ienable, ostate (current value).
module stim_lfsr16
    import frame_stim_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        iclk,
    input  logic        ireset,
    input  logic        ienable,
    output logic [15:0] ostate
);

    logic [15:0] state_q;
    logic [15:0] state_d;

    always_comb begin
        state_d = state_q;
        if (ienable) begin
            state_d = lfsr_step(state_q);
        end
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign ostate = state_q;

endmodule

// File: rtl/frame_stim_gen.sv
// Framed test-traffic generator: header, NUM_CH x WORDS_PER_CH payload,
// XOR trailer. Frames start on a periodic tick or itrig.
// Ports: iclk/ireset (sync, active-high); ienable/iperiod set the tick;
// itrig requests a frame; imode picks the payload; iready is downstream
// ready; odata/ovalid/osof/oeof/och carry words; obusy, oframe_cnt and
// sticky ooverrun report status.
module frame_stim_gen
    import frame_stim_pkg::*;
#(
    parameter int          DATA_W       = 18,
    parameter int          CNT_W        = 26,
    parameter int          NUM_CH       = 4,
    parameter int          WORDS_PER_CH = 8,
    parameter int          CH_W         = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              ienable,
    input  logic [CNT_W-1:0]  iperiod,
    input  logic              itrig,
    input  logic [1:0]        imode,
    input  logic              iready,
    output logic [DATA_W-1:0] odata,
    output logic              ovalid,
    output logic              osof,
    output logic              oeof,
    output logic [CH_W-1:0]   och,
    output logic              obusy,
    output logic [15:0]       oframe_cnt,
    output logic              ooverrun
);

    localparam int NPAY  = NUM_CH * WORDS_PER_CH;
    localparam int IDX_W = (NPAY > 1) ? $clog2(NPAY) : 1;
    localparam int WIC_W = (WORDS_PER_CH > 1) ? $clog2(WORDS_PER_CH) : 1;
    localparam int PAT_W = DATA_W - CH_W;

    state_e             state_q, state_d;
    mode_e              mode_q, mode_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   ts_q, ts_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [WIC_W-1:0]   wic_q, wic_d;
    logic [DATA_W-1:0]  csum_q, csum_d;
    logic [15:0]        frame_cnt_q, frame_cnt_d;
    logic               ovr_q, ovr_d;

    logic               tick;
    logic               start;
    logic               busy;
    logic               xfer;
    logic               lfsr_en;
    logic [15:0]        lfsr;
    logic [PAT_W-1:0]   pattern;
    logic [DATA_W-1:0]  pay_word;
    logic [DATA_W-1:0]  hdr_word;

    stim_lfsr16 #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .iclk    (iclk),
        .ireset  (ireset),
        .ienable (lfsr_en),
        .ostate  (lfsr)
    );

    // Period counter; the >= compare recovers if iperiod shrinks mid-count.
    always_comb begin
        cnt_d = cnt_q;
        tick  = 1'b0;
        if (!ienable || iperiod == '0) begin
            cnt_d = '0;
        end else if (cnt_q >= iperiod - CNT_W'(1)) begin
            cnt_d = '0;
            tick  = 1'b1;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    assign start = tick | itrig;
    assign busy  = (state_q != ST_IDLE);
    assign xfer  = busy & iready;

    always_comb begin
        pattern = '1;
        unique case (mode_q)
            MODE_CNT:  pattern = PAT_W'(idx_q);
            MODE_TS:   pattern = PAT_W'(ts_q + CNT_W'(idx_q));
            MODE_LFSR: pattern = PAT_W'(lfsr);
            default:   pattern = '1;
        endcase
    end

    assign pay_word = {ch_q, pattern};

    // Tag and count are MSB-aligned; the shift drops excess low bits
    // when DATA_W is narrower than the 18-bit tag+count.
    assign hdr_word = DATA_W'({HDR_TAG, frame_cnt_q, {DATA_W{1'b0}}} >> 18);

    always_comb begin
        odata = '0;
        osof  = 1'b0;
        oeof  = 1'b0;
        och   = '0;
        unique case (state_q)
            ST_HDR: begin
                odata = hdr_word;
                osof  = 1'b1;
            end
            ST_PAY: begin
                odata = pay_word;
                och   = ch_q;
            end
            ST_TRL: begin
                odata = csum_q;
                oeof  = 1'b1;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        mode_d      = mode_q;
        ts_d        = ts_q;
        idx_d       = idx_q;
        ch_d        = ch_q;
        wic_d       = wic_q;
        csum_d      = csum_q;
        frame_cnt_d = frame_cnt_q;
        ovr_d       = ovr_q | (start & busy);
        lfsr_en     = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_HDR;
                    mode_d  = mode_e'(imode);
                    ts_d    = cnt_q;
                    idx_d   = '0;
                    ch_d    = '0;
                    wic_d   = '0;
                    csum_d  = '0;
                end
            end
            ST_HDR: begin
                if (xfer) begin
                    state_d = ST_PAY;
                end
            end
            ST_PAY: begin
                if (xfer) begin
                    csum_d  = csum_q ^ pay_word;
                    lfsr_en = (mode_q == MODE_LFSR);
                    idx_d   = idx_q + IDX_W'(1);
                    if (wic_q == WIC_W'(WORDS_PER_CH - 1)) begin
                        wic_d = '0;
                        ch_d  = ch_q + CH_W'(1);
                    end else begin
                        wic_d = wic_q + WIC_W'(1);
                    end
                    if (idx_q == IDX_W'(NPAY - 1)) begin
                        state_d = ST_TRL;
                    end
                end
            end
            ST_TRL: begin
                if (xfer) begin
                    state_d     = ST_IDLE;
                    frame_cnt_d = frame_cnt_q + 16'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge iclk) begin
        if (ireset) begin
            state_q     <= ST_IDLE;
            mode_q      <= MODE_CNT;
            cnt_q       <= '0;
            ts_q        <= '0;
            idx_q       <= '0;
            ch_q        <= '0;
            wic_q       <= '0;
            csum_q      <= '0;
            frame_cnt_q <= '0;
            ovr_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            mode_q      <= mode_d;
            cnt_q       <= cnt_d;
            ts_q        <= ts_d;
            idx_q       <= idx_d;
            ch_q        <= ch_d;
            wic_q       <= wic_d;
            csum_q      <= csum_d;
            frame_cnt_q <= frame_cnt_d;
            ovr_q       <= ovr_d;
        end
    end

    assign ovalid     = busy;
    assign obusy      = busy;
    assign oframe_cnt = frame_cnt_q;
    assign ooverrun   = ovr_q;

endmodule

// File: tb/tb_frame_stim_gen.sv
// Bench for frame_stim_gen with NUM_CH=2, WORDS_PER_CH=2.
// Vector table for the first frames, then hand-written sequences.
module tb_frame_stim_gen;

    localparam int DATA_W = 18;
    localparam int CNT_W  = 26;

    logic              iclk = 1'b0;
    logic              ireset;
    logic              ienable;
    logic [CNT_W-1:0]  iperiod;
    logic              itrig;
    logic [1:0]        imode;
    logic              iready;
    logic [DATA_W-1:0] odata;
    logic              ovalid;
    logic              osof;
    logic              oeof;
    logic [0:0]        och;
    logic              obusy;
    logic [15:0]       oframe_cnt;
    logic              ooverrun;

    frame_stim_gen #(
        .DATA_W       (DATA_W),
        .CNT_W        (CNT_W),
        .NUM_CH       (2),
        .WORDS_PER_CH (2)
    ) dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .ienable    (ienable),
        .iperiod    (iperiod),
        .itrig      (itrig),
        .imode      (imode),
        .iready     (iready),
        .odata      (odata),
        .ovalid     (ovalid),
        .osof       (osof),
        .oeof       (oeof),
        .och        (och),
        .obusy      (obusy),
        .oframe_cnt (oframe_cnt),
        .ooverrun   (ooverrun)
    );

    always #5 iclk = ~iclk;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: accepted words, valid rising edges, stability under stall.
    logic [20:0] acc_q [$];
    int          rise_q [$];
    int          cyc = 0;
    bit          prev_stall = 1'b0;
    bit          prev_valid = 1'b0;
    logic [20:0] prev_bus;

    always @(negedge iclk) begin
        cyc++;
        if (prev_stall) begin
            chk("stall_stable", 64'({osof, oeof, och, odata}), 64'(prev_bus));
        end
        prev_stall = ovalid && !iready;
        prev_bus   = {osof, oeof, och, odata};
        if (ovalid && iready) acc_q.push_back({osof, oeof, och, odata});
        if (ovalid && !prev_valid) rise_q.push_back(cyc);
        prev_valid = ovalid;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct {
        bit          trig;
        logic [1:0]  mode;
        bit          rdy;
        bit          v, s, e;
        logic        ch;
        logic [17:0] d;
        bit          b;
        logic [15:0] fc;
        bit          ov;
    } vec_t;

    function automatic vec_t mk(bit trig, logic [1:0] mode, bit rdy,
                                bit v, bit s, bit e, logic ch,
                                logic [17:0] d, bit b, logic [15:0] fc,
                                bit ov);
        vec_t r;
        r.trig = trig; r.mode = mode; r.rdy = rdy;
        r.v = v; r.s = s; r.e = e; r.ch = ch; r.d = d;
        r.b = b; r.fc = fc; r.ov = ov;
        return r;
    endfunction

    function automatic logic [15:0] ref_lfsr(input logic [15:0] s);
        logic bit_in;
        bit_in = s[0] ^ s[2] ^ s[3] ^ s[5];
        return {bit_in, s[15:1]};
    endfunction

    task automatic do_reset();
        ireset = 1'b1;
        repeat (2) begin
            @(posedge iclk);
            #1;
        end
        ireset = 1'b0;
    endtask

    task automatic check_frame(input string name, input logic [17:0] ew [6]);
        chk({name, "_count"}, 64'(acc_q.size() >= 6), 64'(1));
        for (int i = 0; i < 6 && i < acc_q.size(); i++) begin
            chk($sformatf("%s_w%0d", name, i), 64'(acc_q[i]),
                64'({i == 0, i == 5, (i == 3 || i == 4), ew[i]}));
        end
    endtask

    task automatic wait_words(input int n);
        for (int k = 0; k < 400 && acc_q.size() < n; k++) @(negedge iclk);
    endtask

    vec_t        vt [19];
    logic [17:0] ew [6];
    logic [17:0] x;
    logic [15:0] r;
    int          base;
    bit          found;

    initial begin
        ireset  = 1'b1;
        ienable = 1'b0;
        iperiod = '0;
        itrig   = 1'b0;
        imode   = 2'd0;
        iready  = 1'b1;

        vt[0]  = mk(1, 0, 1, 0, 0, 0, 0, 18'h00000, 0, 0, 0);
        vt[1]  = mk(0, 0, 1, 1, 1, 0, 0, 18'h30000, 1, 0, 0);
        vt[2]  = mk(0, 0, 1, 1, 0, 0, 0, 18'h00000, 1, 0, 0);
        vt[3]  = mk(0, 0, 1, 1, 0, 0, 0, 18'h00001, 1, 0, 0);
        vt[4]  = mk(0, 0, 1, 1, 0, 0, 1, 18'h20002, 1, 0, 0);
        vt[5]  = mk(0, 0, 1, 1, 0, 0, 1, 18'h20003, 1, 0, 0);
        vt[6]  = mk(0, 0, 1, 1, 0, 1, 0, 18'h00000, 1, 0, 0);
        vt[7]  = mk(1, 3, 1, 0, 0, 0, 0, 18'h00000, 0, 1, 0);
        vt[8]  = mk(0, 3, 0, 1, 1, 0, 0, 18'h30001, 1, 1, 0);
        vt[9]  = mk(0, 3, 1, 1, 1, 0, 0, 18'h30001, 1, 1, 0);
        vt[10] = mk(0, 3, 1, 1, 0, 0, 0, 18'h1FFFF, 1, 1, 0);
        vt[11] = mk(0, 3, 0, 1, 0, 0, 0, 18'h1FFFF, 1, 1, 0);
        vt[12] = mk(1, 3, 0, 1, 0, 0, 0, 18'h1FFFF, 1, 1, 0);
        vt[13] = mk(0, 3, 1, 1, 0, 0, 0, 18'h1FFFF, 1, 1, 1);
        vt[14] = mk(0, 3, 1, 1, 0, 0, 1, 18'h3FFFF, 1, 1, 1);
        vt[15] = mk(0, 3, 1, 1, 0, 0, 1, 18'h3FFFF, 1, 1, 1);
        vt[16] = mk(0, 3, 1, 1, 0, 1, 0, 18'h00000, 1, 1, 1);
        vt[17] = mk(0, 3, 1, 0, 0, 0, 0, 18'h00000, 0, 2, 1);
        vt[18] = mk(0, 3, 1, 0, 0, 0, 0, 18'h00000, 0, 2, 1);

        @(posedge iclk);
        @(negedge iclk);
        chk("reset_state",
            64'({ovalid, osof, oeof, och, obusy, ooverrun, oframe_cnt, odata}),
            64'(0));
        do_reset();

        for (int i = 0; i < 19; i++) begin
            itrig  = vt[i].trig;
            imode  = vt[i].mode;
            iready = vt[i].rdy;
            @(negedge iclk);
            chk($sformatf("vec%0d", i),
                64'({ovalid, osof, oeof, och, obusy, ooverrun, oframe_cnt, odata}),
                64'({vt[i].v, vt[i].s, vt[i].e, vt[i].ch, vt[i].b, vt[i].ov,
                     vt[i].fc, vt[i].d}));
            @(posedge iclk);
            #1;
        end
        itrig  = 1'b0;
        iready = 1'b1;

        // Periodic ticks, timestamp payload.
        iperiod = CNT_W'(100);
        ienable = 1'b1;
        imode   = 2'd1;
        do_reset();
        base = cyc;
        acc_q.delete();
        rise_q.delete();
        for (int k = 0; k < 400 && rise_q.size() < 3; k++) @(negedge iclk);
        chk("per_rises", 64'(rise_q.size() >= 3), 64'(1));
        if (rise_q.size() >= 3) begin
            chk("per_first", 64'(rise_q[0] - base), 64'(101));
            chk("per_gap1", 64'(rise_q[1] - rise_q[0]), 64'(100));
            chk("per_gap2", 64'(rise_q[2] - rise_q[1]), 64'(100));
        end
        ew = '{18'h30000, 18'h00063, 18'h00064, 18'h20065, 18'h20066, 18'h00004};
        check_frame("per_frame", ew);
        iperiod = '0;
        wait_words(18);
        rise_q.delete();
        repeat (300) @(negedge iclk);
        chk("per_zero_rises", 64'(rise_q.size()), 64'(0));
        @(posedge iclk);
        #1;
        ienable = 1'b0;

        // LFSR payload under random backpressure, two frames.
        imode = 2'd2;
        do_reset();
        r = 16'hACE1;
        for (int f = 0; f < 2; f++) begin
            acc_q.delete();
            ew[0] = 18'h30000 + 18'(f);
            x = '0;
            for (int i = 0; i < 4; i++) begin
                ew[i+1] = {(i >= 2), 1'b0, r};
                x = x ^ ew[i+1];
                r = ref_lfsr(r);
            end
            ew[5] = x;
            itrig = 1'b1;
            @(posedge iclk);
            #1;
            itrig = 1'b0;
            for (int k = 0; k < 400 && acc_q.size() < 6; k++) begin
                iready = 1'($urandom_range(0, 1));
                @(posedge iclk);
                #1;
            end
            iready = 1'b1;
            check_frame($sformatf("lfsr_f%0d", f), ew);
            chk($sformatf("lfsr_f%0d_exact", f), 64'(acc_q.size()), 64'(6));
        end
        repeat (3) @(posedge iclk);
        #1;

        // Reset in the middle of a payload.
        imode = 2'd0;
        itrig = 1'b1;
        @(posedge iclk);
        #1;
        itrig = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            @(negedge iclk);
            if (ovalid && odata == 18'h20003) found = 1'b1;
        end
        chk("rst_seek", 64'(found), 64'(1));
        ireset = 1'b1;
        @(posedge iclk);
        #1;
        ireset = 1'b0;
        @(negedge iclk);
        chk("rst_mid",
            64'({ovalid, obusy, oframe_cnt, odata}), 64'(0));
        itrig = 1'b1;
        @(posedge iclk);
        #1;
        itrig = 1'b0;
        @(negedge iclk);
        chk("rst_hdr", 64'({ovalid, osof, odata}), 64'({2'b11, 18'h30000}));
        repeat (10) @(posedge iclk);
        #1;

        // Counter wrap, tick coincident with itrig.
        iperiod = CNT_W'(10);
        ienable = 1'b1;
        do_reset();
        acc_q.delete();
        rise_q.delete();
        force dut.frame_cnt_q = 16'hFFFF;
        @(negedge iclk);
        release dut.frame_cnt_q;
        repeat (9) @(posedge iclk);
        #1;
        itrig = 1'b1;
        @(posedge iclk);
        #1;
        itrig   = 1'b0;
        ienable = 1'b0;
        repeat (30) @(negedge iclk);
        ew = '{18'h3FFFF, 18'h00000, 18'h00001, 18'h20002, 18'h20003, 18'h00000};
        check_frame("wrap", ew);
        chk("wrap_one_frame", 64'(rise_q.size()), 64'(1));
        chk("wrap_cnt", 64'(oframe_cnt), 64'(0));
        chk("wrap_no_ovr", 64'(ooverrun), 64'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/frame_stim_gen.md
Name: frame_stim_gen

Overview:
Parametrised successor to the single-channel periodic BLVDS frame stimulus used in simulation tops. It generates framed test traffic: a header word, NUM_CH channel blocks of WORDS_PER_CH payload words, and a checksum trailer. Frames start on a programmable periodic tick or an external trigger, with valid/ready backpressure toward the BLVDS/uPP bridge. It adds selectable payload modes, overrun detection and a frame counter.

Parameters:
DATA_W, 18, output word width; must be >= CH_W+8
CNT_W, 26, period counter width
NUM_CH, 4, channels per frame (>=1)
WORDS_PER_CH, 8, payload words per channel (>=1)
CH_W, $clog2(NUM_CH) min 1, channel index width (derived)
LFSR_SEED, 16'hACE1, LFSR reset value

Ports:
iclk  in  1  single clock
ireset  in  1  synchronous, active-high reset
ienable  in  1  enables the periodic tick counter
iperiod  in  CNT_W  tick period in cycles; 0 disables periodic ticks
itrig  in  1  one-cycle external frame request
imode  in  2  payload mode: 0 counter, 1 timestamp, 2 LFSR, 3 all-ones
iready  in  1  downstream ready
odata  out  DATA_W  frame word
ovalid  out  1  odata valid
osof  out  1  marks the header word
oeof  out  1  marks the trailer word
och  out  CH_W  channel of the current payload word (0 on header/trailer)
obusy  out  1  frame in progress
oframe_cnt  out  16  completed frames
ooverrun  out  1  sticky: a start request arrived while busy

Behaviour:
- Reset (sync, active-high): all outputs 0, period counter 0, LFSR=LFSR_SEED, FSM IDLE. Reset mid-frame abandons the frame; outputs are 0 after the next edge.
- Period counter:
  - while ienable && iperiod!=0, counts 0..iperiod-1 and wraps;
  - tick = one-cycle pulse on wrap;
  - ienable low: counter held at 0; an in-progress frame still completes.
- start = tick | itrig. Coincident tick and itrig start one frame only.
- start while obusy: ooverrun set (sticky until reset); the request is dropped.
- FSM states: IDLE, HDR, PAY, TRL.
  - IDLE -> HDR on start; the cycle after start, ovalid=1 and obusy=1. Start latency is 1 cycle.
  - imode and the timestamp (period counter value at start) are latched on start.
- Handshake: a word transfers when ovalid&&iready. odata, osof, oeof and och are held stable while ovalid&&!iready. ovalid is never withdrawn before acceptance.
- Header: odata = {2'b11, oframe_cnt, zero-pad}, MSB-aligned in DATA_W; osof=1.
- PAY:
  - NUM_CH*WORDS_PER_CH words, channel-major;
  - odata = {ch[CH_W-1:0], pattern} with pattern DATA_W-CH_W bits, zero-extended or truncated from the mode source.
- Mode sources:
  - mode 0: word index within the frame, from 0;
  - mode 1: latched timestamp + word index;
  - mode 2: LFSR x^16+x^14+x^13+x^11+1, advanced on each accepted payload word, persisting across frames;
  - mode 3: all ones.
- Trailer: odata = XOR of all payload odata words of this frame; oeof=1.
- On trailer acceptance: oframe_cnt increments (16'hFFFF wraps to 0), then IDLE. obusy and ovalid fall the next cycle.
- Frame length is 2+NUM_CH*WORDS_PER_CH accepted words. Back-to-back frames need at least one IDLE cycle.

Decomposition:
- Shared package frame_stim_pkg: mode encodings, header tag 2'b11, LFSR taps, state enum.
- Sub-module stim_lfsr16: enable, seed on reset, 16-bit state. The period counter and FSM stay in the top.

Test Plan:
- NUM_CH=2, WORDS_PER_CH=2, mode 0, iready=1, itrig pulse -> 6 words:
  - header osof=1, frame_cnt 0;
  - payloads {0,0},{0,1},{1,2},{1,3};
  - trailer = XOR of the four payloads;
  - then oframe_cnt=1.
- iperiod=100, ienable=1 -> header ovalid rises 1 cycle after each wrap, every 100 cycles; iperiod=0 -> no frames.
- iready toggled randomly, mode 2 -> no word lost or duplicated; data stable while stalled; payload sequence equals the reference LFSR from 16'hACE1.
- itrig during a busy frame -> ooverrun=1 and stays 1; the frame is unaffected; no extra frame follows.
- Reset asserted at payload word 3 -> next cycle ovalid=0, obusy=0; the next itrig yields a header with frame_cnt 0.
- Preload 65535 frames (force counter) -> after one frame oframe_cnt=0; tick and itrig in the same cycle -> exactly one frame.
